// File: rtl/uncache.sv
// Unpacks INPUT-byte words into OUTPUT-group samples, skipping disabled groups; one-cycle latency.
// rdy_o and stb_o depend on registered state only; a stalled sample holds q_o steady.
module uncache #(
    parameter int INPUT  = 4,
    parameter int OUTPUT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_in,
    input  logic                  cfg_stb_i,
    input  logic [OUTPUT-1:0]     cfg_i,
    input  logic                  stb_i,
    output logic                  rdy_o,
    input  logic [INPUT*8-1:0]    d_i,
    output logic                  stb_o,
    input  logic                  rdy_i,
    output logic [OUTPUT*8-1:0]   q_o
);
    localparam int D  = INPUT + OUTPUT - 1;
    localparam int CW = $clog2(D + 1);

    logic [D-1:0][7:0]   data_q, data_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [OUTPUT-1:0]   cfg_q, cfg_d;
    int                  n_en;
    logic                push, pop;

    always_comb begin
        n_en = 0;
        for (int g = 0; g < OUTPUT; g++) begin
            if (!cfg_q[g]) n_en = n_en + 1;
        end
    end

    assign rdy_o = (int'(cnt_q) <= OUTPUT - 1);
    assign stb_o = (n_en != 0) && (int'(cnt_q) >= n_en);
    assign pop   = stb_o && rdy_i;
    assign push  = stb_i && rdy_o && (n_en != 0);

    // Slot 0 always holds the oldest byte; pop shifts down by n, then the word lands at the new tail.
    always_comb begin
        int base;
        data_d = data_q;
        cfg_d  = cfg_q;
        base   = int'(cnt_q);
        if (pop) begin
            for (int i = 0; i < D; i++) begin
                data_d[i] = 8'h00;
                for (int j = 0; j < D; j++) begin
                    if (j == i + n_en) data_d[i] = data_q[j];
                end
            end
            base = base - n_en;
        end
        if (push) begin
            for (int i = 0; i < D; i++) begin
                for (int j = 0; j < INPUT; j++) begin
                    if (i == base + j) data_d[i] = d_i[8*j +: 8];
                end
            end
        end
        cnt_d = CW'(base + (push ? INPUT : 0));
        if (cfg_stb_i) begin
            cfg_d = cfg_i;
            cnt_d = '0;
        end
    end

    // k-th oldest byte goes to the k-th enabled group in ascending order.
    always_comb begin
        int k;
        q_o = '0;
        k   = 0;
        for (int g = 0; g < OUTPUT; g++) begin
            if (!cfg_q[g]) begin
                for (int s = 0; s < OUTPUT; s++) begin
                    if (stb_o && s == k) q_o[8*g +: 8] = data_q[s];
                end
                k = k + 1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            data_q <= '0;
            cnt_q  <= '0;
            cfg_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            cfg_q  <= cfg_d;
        end
    end
endmodule
